// File: rtl/matrix_multiplier.sv
// 2x2 complex fixed-point matrix multiplier, result = A x B.
// One complex MAC unit (4 real multipliers) walks the 8 partial products in
// 8 CALC cycles: elements (0,0),(0,1),(1,0),(1,1), each with k=0 then k=1.
//
// Optional build macro: MATRIX_MULTIPLIER_SAT_EN
//   defined   -> rounded elements saturate and overflow reports any clamp
//   undefined -> rounded elements wrap to NUMERIC_BITS and overflow is tied 0
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   mtx_a, mtx_b    operands, indexed [row][col][part], part 0 = re, 1 = im
//   ready           request a multiply (sampled only in IDLE)
//   busy            high in CALC and DONE
//   multiplier_done one-cycle pulse when a new result is presented
//   result          product, held until the next completion
//   overflow        any component of the last result saturated
module matrix_multiplier #(
  parameter int unsigned NUMERIC_BITS = 18,
  parameter int unsigned FRAC_BITS    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]  mtx_a,
  input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]  mtx_b,
  input  logic                                    ready,
  output logic                                    busy,
  output logic                                    multiplier_done,
  output logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]  result,
  output logic                                    overflow
);

  localparam int unsigned PROD_W = 2 * NUMERIC_BITS;
  localparam int unsigned ACC_W  = 2 * NUMERIC_BITS + 2;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_BITS - 1);

`ifdef MATRIX_MULTIPLIER_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (NUMERIC_BITS - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (NUMERIC_BITS - 1));
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0] a_q;
  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0] b_q;
  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0] staging;
  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0] next_staging;

  logic [2:0]              cnt;
  logic signed [ACC_W-1:0] acc_re;
  logic signed [ACC_W-1:0] acc_im;

  // Step decode: cnt = {row, col, k}
  logic row;
  logic col;
  logic kk;
  assign row = cnt[2];
  assign col = cnt[1];
  assign kk  = cnt[0];

  // Operand selection for A[row][k] x B[k][col]
  logic signed [NUMERIC_BITS-1:0] ar;
  logic signed [NUMERIC_BITS-1:0] ai;
  logic signed [NUMERIC_BITS-1:0] br;
  logic signed [NUMERIC_BITS-1:0] bi;
  assign ar = a_q[row][kk][0];
  assign ai = a_q[row][kk][1];
  assign br = b_q[kk][col][0];
  assign bi = b_q[kk][col][1];

  // Complex MAC: four real multipliers
  logic signed [PROD_W-1:0] p_rr;
  logic signed [PROD_W-1:0] p_ii;
  logic signed [PROD_W-1:0] p_ri;
  logic signed [PROD_W-1:0] p_ir;
  assign p_rr = PROD_W'(ar) * PROD_W'(br);
  assign p_ii = PROD_W'(ai) * PROD_W'(bi);
  assign p_ri = PROD_W'(ar) * PROD_W'(bi);
  assign p_ir = PROD_W'(ai) * PROD_W'(br);

  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  assign sum_re = acc_re + (ACC_W'(p_rr) - ACC_W'(p_ii));
  assign sum_im = acc_im + (ACC_W'(p_ri) + ACC_W'(p_ir));

  // Round half up, then drop the fractional bits of the product scaling
  logic signed [ACC_W-1:0] shift_re;
  logic signed [ACC_W-1:0] shift_im;
  assign shift_re = (sum_re + RND) >>> FRAC_BITS;
  assign shift_im = (sum_im + RND) >>> FRAC_BITS;

  logic [NUMERIC_BITS-1:0] re_val;
  logic [NUMERIC_BITS-1:0] im_val;

`ifdef MATRIX_MULTIPLIER_SAT_EN
  logic clamp;
  logic sticky;
`endif

  // Element narrowing and staging update on the k=1 step
  always_comb begin
    next_staging = staging;
    re_val       = NUMERIC_BITS'(shift_re);
    im_val       = NUMERIC_BITS'(shift_im);
`ifdef MATRIX_MULTIPLIER_SAT_EN
    clamp = 1'b0;
    if (shift_re > SAT_MAX) begin
      re_val = NUMERIC_BITS'(SAT_MAX);
      clamp  = 1'b1;
    end else if (shift_re < SAT_MIN) begin
      re_val = NUMERIC_BITS'(SAT_MIN);
      clamp  = 1'b1;
    end
    if (shift_im > SAT_MAX) begin
      im_val = NUMERIC_BITS'(SAT_MAX);
      clamp  = 1'b1;
    end else if (shift_im < SAT_MIN) begin
      im_val = NUMERIC_BITS'(SAT_MIN);
      clamp  = 1'b1;
    end
    // Only a completed element may contribute to the overflow flag
    if (!kk) begin
      clamp = 1'b0;
    end
`endif
    if (kk) begin
      next_staging[row][col][0] = re_val;
      next_staging[row][col][1] = im_val;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ready) next_state = CALC;
      CALC:    if (cnt == 3'd7) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered status outputs, derived from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy            <= 1'b0;
      multiplier_done <= 1'b0;
    end else begin
      busy            <= (next_state != IDLE);
      multiplier_done <= (next_state == DONE);
    end
  end

  // Datapath: operand capture, accumulation, staging and result update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      staging <= '0;
      result  <= '0;
      cnt     <= 3'd0;
      acc_re  <= '0;
      acc_im  <= '0;
`ifdef MATRIX_MULTIPLIER_SAT_EN
      sticky   <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ready) begin
            a_q    <= mtx_a;
            b_q    <= mtx_b;
            cnt    <= 3'd0;
            acc_re <= '0;
            acc_im <= '0;
`ifdef MATRIX_MULTIPLIER_SAT_EN
            sticky <= 1'b0;
`endif
          end
        end
        CALC: begin
          cnt     <= cnt + 3'd1;
          staging <= next_staging;
          if (kk) begin
            acc_re <= '0;
            acc_im <= '0;
          end else begin
            acc_re <= sum_re;
            acc_im <= sum_im;
          end
`ifdef MATRIX_MULTIPLIER_SAT_EN
          sticky <= sticky | clamp;
`endif
          // Last step: the final element goes straight into result with staging
          if (cnt == 3'd7) begin
            result <= next_staging;
`ifdef MATRIX_MULTIPLIER_SAT_EN
            overflow <= sticky | clamp;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef MATRIX_MULTIPLIER_SAT_EN
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed self-checking bench for matrix_multiplier (Q2.16, 18-bit parts).
module tb_matrix_multiplier;

  localparam int unsigned NB = 18;
  localparam int unsigned FB = 16;

  typedef logic [1:0][1:0][1:0][NB-1:0] mtx_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b0;
  mtx_t mtx_a = '0;
  mtx_t mtx_b = '0;
  mtx_t result;
  logic busy;
  logic multiplier_done;
  logic overflow;

  int checks = 0;
  int errors = 0;

  matrix_multiplier #(.NUMERIC_BITS(NB), .FRAC_BITS(FB)) dut (
    .clk             (clk),
    .reset           (reset),
    .mtx_a           (mtx_a),
    .mtx_b           (mtx_b),
    .ready           (ready),
    .busy            (busy),
    .multiplier_done (multiplier_done),
    .result          (result),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Reference matrices, hand-built
  function automatic mtx_t m_ident();
    mtx_t m = '0;
    m[0][0][0] = NB'(65536);
    m[1][1][0] = NB'(65536);
    return m;
  endfunction

  function automatic mtx_t m_hadamard();
    mtx_t m = '0;
    m[0][0][0] = NB'(46341);
    m[0][1][0] = NB'(46341);
    m[1][0][0] = NB'(46341);
    m[1][1][0] = NB'(-46341);
    return m;
  endfunction

  function automatic mtx_t m_idiag();
    mtx_t m = '0;
    m[0][0][1] = NB'(65536);
    m[1][1][1] = NB'(65536);
    return m;
  endfunction

  function automatic mtx_t m_diag_re(input int v);
    mtx_t m = '0;
    m[0][0][0] = NB'(v);
    m[1][1][0] = NB'(v);
    return m;
  endfunction

  function automatic mtx_t m_all_re(input int v);
    mtx_t m = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        m[r][c][0] = NB'(v);
    return m;
  endfunction

  // Present operands with ready for one capture edge; returns mid cycle N+1
  task automatic start_op(input mtx_t a, input mtx_t b);
    @(negedge clk);
    mtx_a = a;
    mtx_b = b;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  // From mid N+1, count cycles until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 1;
    while (!multiplier_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (multiplier_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", multiplier_done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity_hadamard();
    int lat;
    start_op(m_ident(), m_hadamard());
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ih_busy_calc: got %b want 1", busy); end
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL ih_latency: got %0d want 9", lat); end
    checks++; if (result !== m_hadamard()) begin errors++; $display("FAIL ih_result: got %h want %h", result, m_hadamard()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ih_overflow: got %b want 0", overflow); end
    @(negedge clk);
    checks++; if (multiplier_done !== 1'b0) begin errors++; $display("FAIL ih_done_one_cycle: got %b want 0", multiplier_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ih_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_hadamard_square();
    int lat;
    start_op(m_hadamard(), m_hadamard());
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL hh_latency: got %0d want 9", lat); end
    checks++; if (result !== m_diag_re(65536)) begin errors++; $display("FAIL hh_result: got %h want %h", result, m_diag_re(65536)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hh_overflow: got %b want 0", overflow); end
    @(negedge clk);
  endtask

  task automatic test_imag_diag();
    int lat;
    start_op(m_idiag(), m_idiag());
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL ii_latency: got %0d want 9", lat); end
    checks++; if (result !== m_diag_re(-65536)) begin errors++; $display("FAIL ii_result: got %h want %h", result, m_diag_re(-65536)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ii_overflow: got %b want 0", overflow); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int   lat;
    mtx_t exp_m;
    logic exp_ovf;
`ifdef MATRIX_MULTIPLIER_SAT_EN
    exp_m   = m_all_re(131071);
    exp_ovf = 1'b1;
`else
    exp_m   = m_all_re(32768);
    exp_ovf = 1'b0;
`endif
    start_op(m_all_re(98304), m_all_re(98304));
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL sat_latency: got %0d want 9", lat); end
    checks++; if (result !== exp_m) begin errors++; $display("FAIL sat_result: got %h want %h", result, exp_m); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL sat_overflow: got %b want %b", overflow, exp_ovf); end
    @(negedge clk);
    // A clean operation afterwards must clear the flag again
    start_op(m_ident(), m_ident());
    wait_done(lat);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_overflow_clear: got %b want 0", overflow); end
    checks++; if (result !== m_ident()) begin errors++; $display("FAIL sat_follow_result: got %h want %h", result, m_ident()); end
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int extra = 0;
    start_op(m_ident(), m_hadamard());          // mid N+1
    repeat (2) @(negedge clk);                  // mid N+3
    mtx_a = m_all_re(98304);
    mtx_b = m_idiag();
    ready = 1'b1;
    @(negedge clk);                             // mid N+4
    ready = 1'b0;
    repeat (5) @(negedge clk);                  // mid N+9
    checks++; if (multiplier_done !== 1'b1) begin errors++; $display("FAIL oc_done_n9: got %b want 1", multiplier_done); end
    checks++; if (result !== m_hadamard()) begin errors++; $display("FAIL oc_result: got %h want %h", result, m_hadamard()); end
    ready = 1'b1;                               // sampled while in DONE
    @(negedge clk);                             // mid N+10
    ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oc_ready_in_done_ignored: busy got %b want 0", busy); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (multiplier_done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL oc_extra_done: got %0d want 0", extra); end
    checks++; if (result !== m_hadamard()) begin errors++; $display("FAIL oc_result_held: got %h want %h", result, m_hadamard()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int extra = 0;
    start_op(m_hadamard(), m_hadamard());       // mid N+1
    repeat (3) @(negedge clk);                  // mid N+4
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (multiplier_done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b want 0", multiplier_done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL rm_result: got %h want 0", result); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (multiplier_done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", extra); end
    start_op(m_idiag(), m_idiag());
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL rm_fresh_latency: got %0d want 9", lat); end
    checks++; if (result !== m_diag_re(-65536)) begin errors++; $display("FAIL rm_fresh_result: got %h want %h", result, m_diag_re(-65536)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    @(negedge clk);
    mtx_a = m_hadamard();
    mtx_b = m_hadamard();
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);                             // mid N+1, ready stays high
    mtx_a = m_ident();
    mtx_b = m_hadamard();
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
    checks++; if (result !== m_diag_re(65536)) begin errors++; $display("FAIL b2b_first_result: got %h want %h", result, m_diag_re(65536)); end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!multiplier_done && gap < 30);
    ready = 1'b0;
    checks++; if (gap != 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", gap); end
    checks++; if (result !== m_hadamard()) begin errors++; $display("FAIL b2b_second_result: got %h want %h", result, m_hadamard()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_identity_hadamard();
    test_hadamard_square();
    test_imag_diag();
    test_saturation();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_multiplier.md
MATRIX_MULTIPLIER -- requirements
Module: matrix_multiplier

Interface
REQ-001 SHALL have parameter NUMERIC_BITS, default 18, the signed two's-complement width of each real or imaginary component.
REQ-002 SHALL have parameter FRAC_BITS, default 16, the number of fractional bits: Q2.16, so 1.0 = 65536.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mtx_a, input, NUMERIC_BITS x [1:0][1:0][1:0]: left operand, indexed [row][col][part], where part 0 = real and part 1 = imaginary.
REQ-006 SHALL have port mtx_b, input, same shape as mtx_a: right operand.
REQ-007 SHALL have port ready, input, 1 bit: the operands are valid and a multiply is requested.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port multiplier_done, output, 1 bit: a one-cycle pulse marking a new result.
REQ-010 SHALL have port result, output, same shape as mtx_a: the product A x B.
REQ-011 SHALL have port overflow, output, 1 bit: high for the last result if any element saturated.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 IDLE: when ready = 1 at a clock edge, SHALL latch mtx_a and mtx_b into internal registers, then enter CALC; when ready = 0, SHALL stay in IDLE.
REQ-014 CALC: SHALL use one complex multiply-accumulate unit (4 real multipliers) and run exactly 8 cycles.
- Element order: (0,0), (0,1), (1,0), (1,1).
- Per element: k = 0, then k = 1.
- Each cycle adds A[r][k] x B[k][c] to a full-precision accumulator of at least 2*NUMERIC_BITS+2 bits.
REQ-015 Complex product rule: re = Ar*Br - Ai*Bi; im = Ar*Bi + Ai*Br.
REQ-016 At k = 1, SHALL produce the element once from the accumulator, write it to a staging register, and clear the accumulator.
- Rounding: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
- The value is then saturated or wrapped per REQ-026 and REQ-027.
REQ-017 After the eighth CALC cycle, SHALL enter DONE, copying staging into result and the sticky overflow into overflow on that edge.
REQ-018 DONE: multiplier_done = 1 for exactly one cycle, then return to IDLE; ready is not sampled in DONE.
REQ-019 Latency: if ready is sampled high at the end of cycle N, multiplier_done SHALL be high in cycle N+9.
- Back-to-back throughput: one result per 10 cycles.
REQ-020 busy SHALL be 1 in CALC and DONE and 0 in IDLE; ready SHALL be ignored while busy = 1.
REQ-021 result and overflow SHALL hold their values from the DONE edge until the next DONE edge.
REQ-022 Operand changes after the capture edge SHALL NOT affect the operation in progress.

Reset
REQ-023 When reset = 0, SHALL immediately and asynchronously force:
- state to IDLE;
- busy, multiplier_done and overflow to 0;
- result, staging and accumulator to all zeros;
- the cycle counter to 0.
REQ-024 A reset asserted mid-CALC SHALL abort the operation with no multiplier_done pulse.
REQ-025 After reset deasserts, the first ready sampled high in IDLE SHALL start a fresh operation.

Configuration
REQ-026 With MATRIX_MULTIPLIER_SAT_EN defined:
- each rounded element out of range SHALL clamp to 2^(NUMERIC_BITS-1)-1 or -2^(NUMERIC_BITS-1);
- overflow SHALL go high if any of the 8 components clamped.
REQ-027 Without MATRIX_MULTIPLIER_SAT_EN:
- elements SHALL wrap, keeping the low NUMERIC_BITS bits;
- overflow SHALL be tied to 0;
- no saturation logic SHALL be synthesized.

Verification
REQ-028 Identity x Hadamard: A = I (diagonal re 65536), B = every re 46341 except B[1][1] re = -46341 -> result equals B exactly; multiplier_done at N+9.
REQ-029 Hadamard x Hadamard -> diagonal re = 65536, all other components = 0, overflow = 0.
REQ-030 A = B = diag(i, i), i.e. im = 65536 -> result diagonal re = -65536, im = 0; off-diagonal elements 0.
REQ-031 A = B = all re 98304 (1.5) -> every re = 131071 with overflow = 1 when MATRIX_MULTIPLIER_SAT_EN is defined; every re = 32768 with overflow = 0 without it.
REQ-032 Pulse ready again at cycles N+3 and N+9 with new operands -> the first result is unaffected; the second ready is ignored (DONE); no extra multiplier_done.
REQ-033 Assert reset = 0 at cycle N+4 -> busy, multiplier_done and result all 0 at once; no done pulse; a subsequent multiply completes normally.
